uart_tx: RTL and testbench



---
 rtl/uart_tx_pkg.sv | 21 ++
 rtl/uart_fifo.sv | 55 +++++
 rtl/uart_tx.sv | 179 +++++++++++++++++
 tb/tb_uart_tx.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared constants and types for the memory-mapped UART transmitter.
package uart_tx_pkg;

  // Placement of the UART window in the SoC address map.
  localparam logic [31:0] uart_base_addr = 32'h1000_0000;
  localparam logic [31:0] uart_top_addr  = 32'h1000_000F;

  // Register byte offsets within the UART window.
  localparam logic [3:0] uart_txdata_off = 4'h0;
  localparam logic [3:0] uart_status_off = 4'h4;
  localparam logic [3:0] uart_baud_off   = 4'h8;

  // Serialiser states.
  typedef enum logic [1:0] {
    tx_idle  = 2'd0,
    tx_start = 2'd1,
    tx_data  = 2'd2,
    tx_stop  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/uart_fifo.sv
// Byte FIFO between the bus write port and the serialiser.
module uart_fifo #(
  parameter int depth = 8,
  parameter int width = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [width-1:0]           wdata,
  output logic [width-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(depth):0]     count
);
  localparam int aw = $clog2(depth);

  logic [width-1:0] mem [depth];
  logic [aw-1:0]    wr_ptr_reg;
  logic [aw-1:0]    rd_ptr_reg;
  logic [aw:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO only succeeds when a pop frees a slot that cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign full  = (count_reg == (aw+1)'(depth));
  assign empty = (count_reg == '0);
  assign count = count_reg;
  assign rdata = mem[rd_ptr_reg];

  // Storage array, no reset so it can map onto RAM primitives.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr_reg] <= wdata;
  end

  // Pointers wrap naturally because depth is a power of two.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end
endmodule

// File: rtl/uart_tx.sv
// Memory-mapped 8N1 UART transmitter: bus registers, TX FIFO and serialiser.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int fifo_depth   = 8,
  parameter int clks_per_bit = 868
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        uart_valid,
  input  logic        uart_instr,
  input  logic [31:0] uart_addr,
  input  logic [31:0] uart_wdata,
  input  logic [3:0]  uart_wstrb,
  output logic [31:0] uart_rdata,
  output logic        uart_ready,
  output logic        uart_txd,
  output logic        uart_irq
);
  localparam int cw = $clog2(fifo_depth) + 1;

  logic [3:0]  reg_off;
  logic        bus_write;
  logic        txdata_push;
  logic        fifo_pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic [7:0]  fifo_rdata;
  logic [cw-1:0] fifo_count;
  logic [31:0] count_ext;
  logic [3:0]  count_sat;
  logic [31:0] rd_data;
  logic [15:0] baud_wr_val;

  logic        ready_reg;
  logic [31:0] rdata_reg;
  logic        overflow_reg;
  logic [15:0] baud_reg;

  tx_state_t   state_reg, state_next;
  logic [15:0] cnt_reg, cnt_next;
  logic [15:0] div_reg, div_next;
  logic [2:0]  bit_reg, bit_next;
  logic [7:0]  shift_reg, shift_next;
  logic        txd_reg, txd_next;

  logic        unused_bits;
  assign unused_bits = ^{uart_addr[31:4], uart_addr[1:0], uart_wdata[31:16], uart_wstrb[3:2]};

  // Instruction fetches never write, whatever the strobes say.
  assign reg_off     = {uart_addr[3:2], 2'b00};
  assign bus_write   = uart_valid && !uart_instr && (uart_wstrb != 4'b0000);
  assign txdata_push = bus_write && (reg_off == uart_txdata_off) && uart_wstrb[0];

  uart_fifo #(.depth(fifo_depth), .width(8)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (txdata_push),
    .pop   (fifo_pop),
    .wdata (uart_wdata[7:0]),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign count_ext = 32'(fifo_count);
  assign count_sat = (count_ext > 32'd15) ? 4'hF : count_ext[3:0];

  // Register read mux and BAUD write merge; zero divisors become 1.
  always_comb begin
    rd_data = '0;
    case (reg_off)
      uart_status_off: rd_data = {24'b0, count_sat, overflow_reg,
                                  (state_reg != tx_idle), fifo_empty, fifo_full};
      uart_baud_off:   rd_data = {16'b0, baud_reg};
      default:         rd_data = '0;
    endcase
    baud_wr_val = {uart_wstrb[1] ? uart_wdata[15:8] : baud_reg[15:8],
                   uart_wstrb[0] ? uart_wdata[7:0]  : baud_reg[7:0]};
    if (baud_wr_val == 16'd0) baud_wr_val = 16'd1;
  end

  // Bus response, overflow flag and BAUD register.
  always_ff @(posedge clock) begin
    if (reset) begin
      ready_reg    <= 1'b0;
      rdata_reg    <= '0;
      overflow_reg <= 1'b0;
      baud_reg     <= 16'(clks_per_bit);
    end else begin
      ready_reg <= uart_valid;
      rdata_reg <= (uart_valid && !bus_write) ? rd_data : 32'd0;
      if (txdata_push && fifo_full && !fifo_pop) begin
        overflow_reg <= 1'b1;
      end else if (bus_write && (reg_off == uart_status_off) &&
                   uart_wstrb[0] && uart_wdata[3]) begin
        overflow_reg <= 1'b0;
      end
      if (bus_write && (reg_off == uart_baud_off) && (uart_wstrb[1:0] != 2'b00)) begin
        baud_reg <= baud_wr_val;
      end
    end
  end

  // Serialiser state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= tx_idle;
      cnt_reg   <= '0;
      div_reg   <= 16'd1;
      bit_reg   <= '0;
      shift_reg <= '0;
      txd_reg   <= 1'b1;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      div_reg   <= div_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      txd_reg   <= txd_next;
    end
  end

  // Serialiser next state; txd is registered from the next state so it never glitches.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    div_next   = div_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    fifo_pop   = 1'b0;
    case (state_reg)
      tx_idle: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          shift_next = fifo_rdata;
          div_next   = baud_reg;
          cnt_next   = baud_reg - 16'd1;
          state_next = tx_start;
        end
      end
      tx_start: begin
        if (cnt_reg == 16'd0) begin
          cnt_next   = div_reg - 16'd1;
          bit_next   = 3'd0;
          state_next = tx_data;
        end else begin
          cnt_next = cnt_reg - 16'd1;
        end
      end
      tx_data: begin
        if (cnt_reg == 16'd0) begin
          cnt_next   = div_reg - 16'd1;
          shift_next = {1'b0, shift_reg[7:1]};
          if (bit_reg == 3'd7) state_next = tx_stop;
          else                 bit_next   = bit_reg + 3'd1;
        end else begin
          cnt_next = cnt_reg - 16'd1;
        end
      end
      tx_stop: begin
        if (cnt_reg == 16'd0) state_next = tx_idle;
        else                  cnt_next   = cnt_reg - 16'd1;
      end
      default: state_next = tx_idle;
    endcase
    case (state_next)
      tx_start: txd_next = 1'b0;
      tx_data:  txd_next = shift_next[0];
      default:  txd_next = 1'b1;
    endcase
  end

  assign uart_ready = ready_reg;
  assign uart_rdata = rdata_reg;
  assign uart_txd   = txd_reg;
  assign uart_irq   = fifo_empty && (state_reg == tx_idle);
endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: bus responses and serial frames are checked
// by independent monitors against expectations queued by the stimulus.
module tb_uart_tx;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        uart_valid = 1'b0;
  logic        uart_instr = 1'b0;
  logic [31:0] uart_addr = '0;
  logic [31:0] uart_wdata = '0;
  logic [3:0]  uart_wstrb = '0;
  logic [31:0] uart_rdata;
  logic        uart_ready;
  logic        uart_txd;
  logic        uart_irq;

  uart_tx #(.fifo_depth(8), .clks_per_bit(868)) dut (
    .clock      (clock),
    .reset      (reset),
    .uart_valid (uart_valid),
    .uart_instr (uart_instr),
    .uart_addr  (uart_addr),
    .uart_wdata (uart_wdata),
    .uart_wstrb (uart_wstrb),
    .uart_rdata (uart_rdata),
    .uart_ready (uart_ready),
    .uart_txd   (uart_txd),
    .uart_irq   (uart_irq)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;
  int frames_seen = 0;
  int last_edge = 0;

  typedef struct { logic [31:0] addr; logic [31:0] data; bit chk; } rd_exp_t;
  typedef struct { logic [7:0] data; int div; } fr_exp_t;
  rd_exp_t rd_q[$];
  fr_exp_t fr_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Issue one request (caller sits just after a rising edge); returns after the sampling edge.
  task automatic bus(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                     input logic instr, input logic [31:0] exp, input bit chk);
    rd_exp_t e;
    uart_valid = 1'b1;
    uart_addr  = addr;
    uart_wdata = wdata;
    uart_wstrb = wstrb;
    uart_instr = instr;
    e.addr = addr; e.data = exp; e.chk = chk;
    rd_q.push_back(e);
    @(posedge clock);
    #1;
    last_edge = cyc;
  endtask

  task automatic bus_idle();
    uart_valid = 1'b0;
    uart_wstrb = 4'h0;
    uart_instr = 1'b0;
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp);
    bus(addr, 32'h0, 4'h0, 1'b0, exp, 1'b1);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] wdata);
    bus(addr, wdata, 4'hF, 1'b0, 32'h0, 1'b0);
  endtask

  // Byte write to TXDATA; the byte is expected on the line at the given divisor.
  task automatic send(input logic [7:0] b, input int div);
    fr_exp_t f;
    wr(32'h0, {24'hA5A5A5, b});
    f.data = b; f.div = div;
    fr_q.push_back(f);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (!(uart_irq === 1'b1 && fr_q.size() == 0) && n < budget) begin
      step(1);
      n++;
    end
    vectors++;
    if (n >= budget) begin
      miscompares++;
      $display("FAIL idle_timeout: irq=%0b frames_pending=%0d after %0d cycles", uart_irq, fr_q.size(), n);
    end
  endtask

  // Bus monitor: ready must follow each sampled valid by exactly one cycle.
  logic prev_valid = 1'b0;
  always @(negedge clock) begin
    if (reset) begin
      prev_valid = 1'b0;
    end else begin
      if (uart_ready || prev_valid) begin
        check("ready_latency", {31'b0, uart_ready}, {31'b0, prev_valid});
        if (uart_ready) begin
          if (rd_q.size() == 0) begin
            check("ready_unexpected", 32'd1, 32'd0);
          end else begin
            rd_exp_t e;
            e = rd_q.pop_front();
            $display("bus   addr=0x%01h rdata=0x%08h", e.addr[3:0], uart_rdata);
            if (e.chk) check("rdata", uart_rdata, e.data);
          end
        end
      end
      prev_valid = uart_valid;
    end
  end

  // Serial monitor: every cycle of a frame must carry the expected level.
  initial begin
    forever begin
      @(negedge clock);
      if (!reset && uart_txd === 1'b0) begin
        if (fr_q.size() == 0) begin
          check("unexpected_frame", 32'd1, 32'd0);
          while (uart_txd === 1'b0 && !reset) @(negedge clock);
        end else begin
          fr_exp_t e;
          int bad = 0;
          bit abort = 1'b0;
          logic [7:0] got = '0;
          e = fr_q.pop_front();
          for (int k = 0; k < 10 && !abort; k++) begin
            for (int j = 0; j < e.div && !abort; j++) begin
              logic lvl;
              if (!(k == 0 && j == 0)) @(negedge clock);
              if (reset) begin
                abort = 1'b1;
              end else begin
                lvl = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : e.data[k-1];
                if (uart_txd !== lvl) bad++;
                if (k >= 1 && k <= 8 && j == e.div / 2) got[k-1] = uart_txd;
              end
            end
          end
          if (!abort) begin
            frames_seen++;
            $display("frame byte=0x%02h div=%0d bad_samples=%0d", got, e.div, bad);
            check("frame", {got, 24'(bad)}, {e.data, 24'd0});
          end
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e1;
    int frames_before;
    logic [7:0] b;
    int d;
    int n;
    logic [3:0] s;

    // Reset state.
    step(3);
    reset = 1'b0;
    check("reset_txd", {31'b0, uart_txd}, 32'd1);
    check("reset_irq", {31'b0, uart_irq}, 32'd1);
    check("reset_ready", {31'b0, uart_ready}, 32'd0);
    check("reset_rdata", uart_rdata, 32'd0);
    rd(32'h4, 32'h2);
    rd(32'h8, 32'd868);

    // Unmapped and read-side behaviour.
    rd(32'hC, 32'h0);
    wr(32'hC, 32'hFFFF_FFFF);
    rd(32'h8, 32'd868);
    rd(32'h0, 32'h0);
    bus(32'h0, 32'h0000_00A5, 4'h1, 1'b1, 32'h0, 1'b1);
    bus(32'h4, 32'h0000_0008, 4'hF, 1'b1, 32'h2, 1'b1);
    rd(32'h6, 32'h2);

    // A zero divisor is stored as one.
    wr(32'h8, 32'h0);
    rd(32'h8, 32'h1);

    // Single frame at 4 clocks per bit.
    wr(32'h8, 32'd4);
    send(8'h55, 4);
    bus_idle();
    wait_idle(200);
    check("irq_after_stop", {31'b0, uart_irq}, 32'd1);
    rd(32'h4, 32'h2);

    // Divisor change while a frame is in flight applies to the next frame only.
    wr(32'h8, 32'd3);
    send(8'hC3, 3);
    wr(32'h8, 32'd5);
    send(8'h3C, 5);
    bus_idle();
    wait_idle(300);

    // Overflow: one byte leaves at once, eight fill the FIFO, the tenth is dropped.
    wr(32'h8, 32'd100);
    for (int i = 0; i < 10; i++) begin
      b = 8'($urandom);
      if (i < 9) send(b, 100);
      else       wr(32'h0, {24'h0, b});
    end
    rd(32'h4, 32'h8D);
    wr(32'h4, 32'h8);
    rd(32'h4, 32'h85);
    bus_idle();
    wait_idle(12000);
    rd(32'h4, 32'h2);

    // Push coinciding with the serialiser pop while the FIFO is full.
    wr(32'h8, 32'd4);
    send(8'h01, 4);
    e1 = last_edge;
    for (int i = 0; i < 8; i++) send(8'(8'h10 + i), 4);
    bus_idle();
    step(e1 + 41 - cyc);
    send(8'hEE, 4);
    rd(32'h4, 32'h85);
    bus_idle();
    wait_idle(1000);
    rd(32'h4, 32'h2);

    // Randomised bursts with random divisors and strobes.
    for (int it = 0; it < 8; it++) begin
      d = int'($urandom_range(1, 8));
      n = int'($urandom_range(1, 8));
      wr(32'h8, 32'(d));
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        s = 4'($urandom);
        if (s[0]) begin
          fr_exp_t f;
          bus(32'h0, {24'h0, b}, s, 1'b0, 32'h0, s == 4'h0);
          f.data = b; f.div = d;
          fr_q.push_back(f);
        end else begin
          bus(32'h0, {24'h0, b}, s, 1'b0, 32'h0, s == 4'h0);
        end
      end
      bus_idle();
      wait_idle(n * (10 * d + 1) + 50);
      rd(32'h4, 32'h2);
    end

    // Reset during data bit 3 with two more bytes queued.
    wr(32'h8, 32'd4);
    send(8'h00, 4);
    e1 = last_edge;
    send(8'h00, 4);
    send(8'h00, 4);
    bus_idle();
    step(e1 + 18 - cyc);
    reset = 1'b1;
    step(1);
    fr_q.delete();
    rd_q.delete();
    check("reset_mid_txd", {31'b0, uart_txd}, 32'd1);
    check("reset_mid_ready", {31'b0, uart_ready}, 32'd0);
    step(2);
    reset = 1'b0;
    frames_before = frames_seen;
    rd(32'h4, 32'h2);
    bus_idle();
    step(300);
    check("no_frames_after_reset", 32'(frames_seen), 32'(frames_before));
    check("irq_after_reset", {31'b0, uart_irq}, 32'd1);

    step(2);
    check("bus_queue_drained", 32'(rd_q.size()), 32'd0);
    check("frame_queue_drained", 32'(fr_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
